skid_buffer: RTL and testbench

Two-entry valid/ready pipeline stage that sits directly downstream of a data register. It turns the register's enable-style output into a fully registered streaming handshake, with no combinational path from `out_ready` to `in_ready`. A skid slot absorbs the one transfer that arrives while downstream stalls. This gives full throughput with registered `in_ready`, `out_valid` and `out_data`.

---
 rtl/skid_buffer_pkg.sv | 16 +
 rtl/register_en_async_rst.sv | 21 ++
 rtl/skid_buffer.sv | 136 +++++++++++++
 tb/tb_skid_buffer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/skid_buffer_pkg.sv
// Shared types and constants for the skid_buffer stage.
// Holds the FSM state encoding and the stall counter sizing helpers.
package skid_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int STALL_CNT_W_DEF = 16;

    // Wide all-ones constant; the top slices it down to its counter width.
    localparam logic [63:0] STALL_CNT_ALL_ONES = '1;

endpackage

// File: rtl/register_en_async_rst.sv
// Enable-gated data register with asynchronous active-high clear.
// Latency one cycle; no backpressure, loads whenever en_i is high.
module register_en_async_rst #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry registered valid/ready stage (main + skid slot), strict FIFO order.
// Latency 1 cycle; in_ready is registered and drops only when the skid slot fills.
// Optional saturating stall counter enabled by macro SKID_BUFFER_STALL_CNT_EN.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STALL_CNT_WIDTH = STALL_CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             main_from_skid;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) state_d = BUSY;
            end
            BUSY: begin
                if (in_fire && !out_fire)      state_d = FULL;
                else if (!in_fire && out_fire) state_d = EMPTY;
            end
            FULL: begin
                if (out_fire) state_d = BUSY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake flags are decoded from the next state so they leave flops directly.
    always_comb begin
        out_valid_d    = (state_d != EMPTY);
        in_ready_d     = (state_d != FULL);
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (state_q)
            EMPTY: main_en = in_fire;
            BUSY: begin
                main_en = in_fire && out_fire;
                skid_en = in_fire && !out_fire;
            end
            FULL: begin
                main_en        = out_fire;
                main_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    register_en_async_rst #(.WIDTH(WIDTH)) u_main_slot (
        .clk  (clk),
        .rst  (rst),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (out_data)
    );

    register_en_async_rst #(.WIDTH(WIDTH)) u_skid_slot (
        .clk  (clk),
        .rst  (rst),
        .en_i (skid_en),
        .d_i  (in_data),
        .q_o  (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifdef SKID_BUFFER_STALL_CNT_EN
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_MAX =
        STALL_CNT_ALL_ONES[STALL_CNT_WIDTH-1:0];

    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Directed bench for skid_buffer: reset, skid fill, saturation, streaming,
// simultaneous fire and a random-backpressure scoreboard run.
module tb_skid_buffer;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef SKID_BUFFER_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    skid_buffer #(.WIDTH(W), .STALL_CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] sb[$];
    logic [W-1:0] nxt;
    logic [W-1:0] held;
    logic         stalled;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_stall",     32'(stall_count), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        tick();
        rst = 1'b0;

        // Skid fill with downstream stalled
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        check("fill1_valid", 32'(out_valid), 32'd1);
        check("fill1_data",  32'(out_data),  32'h11);
        check("fill1_ready", 32'(in_ready),  32'd1);
        in_data = 8'h22;
        tick();
        check("fill2_ready", 32'(in_ready), 32'd0);
        check("fill2_data",  32'(out_data), 32'h11);
        in_valid = 1'b0;
        tick();
        check("fill3_ready", 32'(in_ready), 32'd0);
        check("fill3_data",  32'(out_data), 32'h11);
        check("fill3_stall", 32'(stall_count), CNT_EN ? 32'd2 : 32'd0);
        out_ready = 1'b1;
        tick();
        check("drain1_data",  32'(out_data),  32'h22);
        check("drain1_valid", 32'(out_valid), 32'd1);
        check("drain1_ready", 32'(in_ready),  32'd1);
        tick();
        check("drain2_valid", 32'(out_valid), 32'd0);

        // Stall counter saturation
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        repeat (12) tick();
        check("sat_mid", 32'(stall_count), CNT_EN ? 32'd14 : 32'd0);
        repeat (8) tick();
        check("sat_end",  32'(stall_count), CNT_EN ? 32'd15 : 32'd0);
        check("sat_hold", 32'(out_data), 32'h33);
        out_ready = 1'b1;
        tick();
        check("sat_drain", 32'(out_valid), 32'd0);

        // Reset while FULL with 0xA, 0xB
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
        tick();
        in_data = 8'h0B;
        tick();
        in_valid = 1'b0;
        check("pre_rst_ready", 32'(in_ready), 32'd0);
        check("pre_rst_data",  32'(out_data), 32'h0A);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid),   32'd0);
        check("mid_rst_ready", 32'(in_ready),    32'd1);
        check("mid_rst_stall", 32'(stall_count), 32'd0);
        in_valid = 1'b1; in_data = 8'hEE;
        tick();
        check("rst_ignore", 32'(out_valid), 32'd0);
        rst = 1'b0; in_data = 8'h0C; out_ready = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data",  32'(out_data),  32'h0C);
        in_valid = 1'b0;
        tick();
        check("post_rst_empty", 32'(out_valid), 32'd0);

        // Full-rate streaming
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data",  32'(out_data),  32'(i));
            check("stream_ready", 32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end", 32'(out_valid), 32'd0);

        // Simultaneous input and output fire in BUSY
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40;
        tick();
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_data = W'(8'h40 + k);
            tick();
            check("simul_data",  32'(out_data),  32'(8'h40 + k));
            check("simul_ready", 32'(in_ready),  32'd1);
            check("simul_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("simul_empty", 32'(out_valid),   32'd0);
        check("simul_stall", 32'(stall_count), 32'd0);

        // Random backpressure against a queue model
        nxt = '0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_valid", 32'(out_valid), 32'(sb.size() != 0));
            check("rnd_ready", 32'(in_ready),  32'(sb.size() < 2));
            if (stalled) check("rnd_hold", 32'(out_data), 32'(held));
            if (out_valid && sb.size() != 0) check("rnd_data", 32'(out_data), 32'(sb[0]));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = nxt;
            stalled   = out_valid && !out_ready;
            held      = out_data;
            if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
            if (in_valid && in_ready) begin
                sb.push_back(nxt);
                nxt = nxt + 1'b1;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            if (out_valid && sb.size() != 0) begin
                check("rnd_drain_data", 32'(out_data), 32'(sb[0]));
                void'(sb.pop_front());
            end
            tick();
        end
        check("rnd_drain_valid", 32'(out_valid), 32'd0);
        check("rnd_drain_left",  32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
